keypad_event_decoder: RTL and testbench
=======================================

# keypad_event_decoder

Consumer end of the 4x4 keypad scanner interface. It takes the scanner's 16-bit pressed-key bitmap and its change strobe, and debounces the bitmap over a programmable number of clock cycles. It converts every confirmed bitmap change into discrete press/release events and buffers them in a small FIFO. The FIFO is read through a valid/ready handshake by the downstream application logic, such as a display or calculator FSM.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive cycles the bitmap must stay constant before it is committed; legal range ≥2.
- FIFO_DEPTH, 4: event FIFO entries; must be a power of 2, ≥2.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- key  in  16  pressed-key bitmap from the scanner; bit i=1 means key i is held.
- change  in  1  scanner change strobe; one-cycle pulse.
- ev_valid  out  1  FIFO head holds an event.
- ev_ready  in  1  consumer accepts the head event.
- ev_code  out  4  key index of the head event.
- ev_press  out  1  1 = press, 0 = release.
- stable_keys  out  16  last committed bitmap.
- busy  out  1  state is not IDLE.

## Operation
- State machine states: IDLE, DEBOUNCE, EMIT.
- Internal registers: cand[15:0], cnt, diff[15:0], idx[3:0].
- IDLE:
  - If change=1 or key≠stable_keys: cand<=key, cnt<=0, go to DEBOUNCE.
- DEBOUNCE, checked in this priority order:
  - If key≠cand: cand<=key, cnt<=0, stay in DEBOUNCE.
  - Else if cnt==DEBOUNCE_CYCLES-1:
    - If cand==stable_keys (bounce returned to the original value): go to IDLE, no events.
    - Otherwise: diff<=cand^stable_keys, stable_keys<=cand, idx<=0, go to EMIT.
  - Else cnt<=cnt+1.
- EMIT (one bit index examined per cycle, ascending 0..15):
  - If diff[idx]=1 and the FIFO is full: hold idx; nothing is dropped.
  - If diff[idx]=1 and the FIFO is not full: push {press=stable_keys[idx], code=idx}, then advance.
  - If diff[idx]=0: advance.
  - Advancing at idx=15 goes to IDLE.
  - key and change are ignored during EMIT. Any change that occurred is caught in IDLE by the key≠stable_keys check.
- FIFO behaviour:
  - First-word-fall-through; ev_code and ev_press are valid whenever ev_valid=1.
  - Pop happens on ev_valid & ev_ready.
  - A push is blocked when the FIFO is full, even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle (not full, not empty) leave the occupancy unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Occupancy counter is log2(FIFO_DEPTH)+1 bits wide.
- Event ordering: events appear strictly in ascending code order within one commit. Commits appear in commit order.

## Timing
- Reset, asynchronous:
  - State IDLE; FIFO empty.
  - ev_valid=0, ev_code=0, ev_press=0, stable_keys=0, busy=0.
  - cand, cnt, diff and idx cleared.
- Reset asserted mid-DEBOUNCE or mid-EMIT:
  - Immediate return to the reset values.
  - Queued events are discarded; un-emitted bits are lost.
- Latency for a key change first seen at cycle T with the bitmap stable afterwards:
  - DEBOUNCE is entered at T+1.
  - Commit happens at T+DEBOUNCE_CYCLES; stable_keys updates at the same edge.
  - EMIT starts at T+DEBOUNCE_CYCLES+1.
  - The event for index i is pushed at T+DEBOUNCE_CYCLES+1+i.
  - ev_valid for that event rises one cycle after the push.
- busy=1 from T+1 through the last EMIT cycle.
- An ev_valid/ev_code/ev_press that has been presented stays stable until it is popped.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, FIFO_DEPTH=4, ev_ready=1 unless stated otherwise.

- **Single press:** key 0x0000→0x0020 at T with change pulse → exactly one event {press=1, code=5}; ev_valid rises at T+11; stable_keys=0x0020 from T+4.
- **Bounce rejection:** key=0x0020 for 2 cycles, then back to 0x0000 → no events; busy returns to 0; stable_keys stays 0x0000.
- **Multi-key change:** stable 0x0001, key→0x8000 → events {0,code 0} then {1,code 15}, in that order; stable_keys=0x8000.
- **Backpressure:** ev_ready=0, key 0x0000→0x003F → FIFO fills with codes 0–3 and EMIT stalls at idx 4. Raise ev_ready → codes 0–5 are all delivered, ascending, with nothing dropped.
- **Change during EMIT:** key changes to 0x0100 while emitting the 0x00FF press events → the 8 press events are followed by a new commit: release codes 0–7, then press code 8.
- **Reset mid-EMIT:** assert rst_n=0 with 2 events queued → ev_valid=0 and stable_keys=0 immediately. After release, key=0x0000 produces no events.

Source files
------------

// File: rtl/keypad_event_if.sv
// Press/release event stream from the keypad decoder to its consumer.
// Valid/ready handshake; the head event holds while ev_valid=1 and ev_ready=0.
interface keypad_event_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [3:0] ev_code;
  logic       ev_press;

  modport master (output ev_valid, output ev_code, output ev_press, input ev_ready);
  modport slave  (input ev_valid, input ev_code, input ev_press, output ev_ready);
endinterface

// File: rtl/keypad_event_decoder.sv
// Debounces the keypad bitmap and emits one press/release event per changed key via a FWFT FIFO.
// Events are pushed DEBOUNCE_CYCLES+1+i cycles after a change. A full FIFO stalls emission without dropping events.
module keypad_event_decoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           key,
  input  logic                  change,
  keypad_event_if.master        ev,
  output logic [15:0]           stable_keys,
  output logic                  busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, EMIT} state_t;

  typedef struct packed {
    logic       press;
    logic [3:0] code;
  } ev_t;

  state_t        state;
  logic [15:0]   cand;
  logic [CW-1:0] cnt;
  logic [15:0]   diff;
  logic [3:0]    idx;

  ev_t           mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          push;
  logic          pop;

  assign full = (count == CNT_FULL);
  assign push = (state == EMIT) && diff[idx] && !full;
  assign pop  = ev.ev_valid && ev.ev_ready;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cand        <= '0;
      cnt         <= '0;
      diff        <= '0;
      idx         <= '0;
      stable_keys <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (change || (key != stable_keys)) begin
            cand  <= key;
            cnt   <= '0;
            state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (key != cand) begin
            cand <= key;
            cnt  <= '0;
          end else if (cnt == CNT_LAST) begin
            // A bounce that settles back to the committed value produces nothing.
            if (cand == stable_keys) begin
              state <= IDLE;
            end else begin
              diff        <= cand ^ stable_keys;
              stable_keys <= cand;
              idx         <= '0;
              state       <= EMIT;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        EMIT: begin
          if (!(diff[idx] && full)) begin
            idx <= idx + 1'b1;
            if (idx == 4'd15) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Push is gated on full alone, so a simultaneous pop never frees a slot early.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{press: stable_keys[idx], code: idx};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign ev.ev_valid = (count != '0);
  assign ev.ev_code  = ev.ev_valid ? mem[rd_ptr].code  : 4'd0;
  assign ev.ev_press = ev.ev_valid ? mem[rd_ptr].press : 1'b0;

endmodule

// File: tb/tb_keypad_event_decoder.sv
// Directed bench for keypad_event_decoder: expected events go into a queue, a monitor pops and compares.
module tb_keypad_event_decoder;
  localparam int DC = 4;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] key;
  logic        change;
  logic [15:0] stable_keys;
  logic        busy;

  keypad_event_if ev_if();

  keypad_event_decoder #(.DEBOUNCE_CYCLES(DC), .FIFO_DEPTH(FD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key         (key),
    .change      (change),
    .ev          (ev_if),
    .stable_keys (stable_keys),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [4:0] exp_q[$];   // {press, code}
  logic [4:0] mon_got;
  logic [4:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input logic press, input logic [3:0] code);
    exp_q.push_back({press, code});
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || ev_if.ev_valid) && n < 300) begin
      step(1);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s_timeout: busy=%0b ev_valid=%0b still set after %0d cycles", name, busy, ev_if.ev_valid, n);
    end
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard monitor: one handshake per negedge sample.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ev_if.ev_valid === 1'b1 && ev_if.ev_ready === 1'b1) begin
      mon_got = {ev_if.ev_press, ev_if.ev_code};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got press=%0b code=%0d, none required", mon_got[4], mon_got[3:0]);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("event", 32'(mon_got), 32'(mon_exp));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    key = 16'h0000;
    change = 1'b0;
    ev_if.ev_ready = 1'b1;
    step(2);
    chk("rst_ev_valid", 32'(ev_if.ev_valid), 32'd0);
    chk("rst_ev_code", 32'(ev_if.ev_code), 32'd0);
    chk("rst_ev_press", 32'(ev_if.ev_press), 32'd0);
    chk("rst_stable", 32'(stable_keys), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step(2);

    // Single press with latency checks
    expect_ev(1'b1, 4'd5);
    key = 16'h0020; change = 1'b1;
    step(1);
    change = 1'b0;
    chk("sp_busy", 32'(busy), 32'd1);
    step(3);
    chk("sp_stable_pre", 32'(stable_keys), 32'h0000);
    step(1);
    chk("sp_stable_post", 32'(stable_keys), 32'h0020);
    step(5);
    chk("sp_valid_early", 32'(ev_if.ev_valid), 32'd0);
    step(1);
    chk("sp_valid_rise", 32'(ev_if.ev_valid), 32'd1);
    chk("sp_code", 32'(ev_if.ev_code), 32'd5);
    wait_idle("single");

    expect_ev(1'b0, 4'd5);
    key = 16'h0000;
    step(1);
    wait_idle("release5");

    // Bounce rejection
    key = 16'h0020;
    step(2);
    key = 16'h0000;
    step(1);
    chk("bounce_busy", 32'(busy), 32'd1);
    wait_idle("bounce");
    chk("bounce_stable", 32'(stable_keys), 32'h0000);

    // Multi-key change
    expect_ev(1'b1, 4'd0);
    key = 16'h0001; change = 1'b1;
    step(1);
    change = 1'b0;
    wait_idle("multi_setup");
    expect_ev(1'b0, 4'd0);
    expect_ev(1'b1, 4'd15);
    key = 16'h8000;
    step(1);
    wait_idle("multi");
    chk("multi_stable", 32'(stable_keys), 32'h8000);
    expect_ev(1'b0, 4'd15);
    key = 16'h0000;
    step(1);
    wait_idle("multi_clear");

    // Backpressure
    ev_if.ev_ready = 1'b0;
    for (int i = 0; i < 6; i++) expect_ev(1'b1, 4'(i));
    key = 16'h003F; change = 1'b1;
    step(1);
    change = 1'b0;
    step(20);
    chk("bp_busy_stalled", 32'(busy), 32'd1);
    chk("bp_valid", 32'(ev_if.ev_valid), 32'd1);
    chk("bp_head_code", 32'(ev_if.ev_code), 32'd0);
    step(5);
    chk("bp_head_hold", 32'(ev_if.ev_code), 32'd0);
    chk("bp_head_press", 32'(ev_if.ev_press), 32'd1);
    ev_if.ev_ready = 1'b1;
    wait_idle("backpressure");
    chk("bp_stable", 32'(stable_keys), 32'h003F);
    for (int i = 0; i < 6; i++) expect_ev(1'b0, 4'(i));
    key = 16'h0000;
    step(1);
    wait_idle("bp_clear");

    // Change during EMIT
    for (int i = 0; i < 8; i++) expect_ev(1'b1, 4'(i));
    key = 16'h00FF; change = 1'b1;
    step(1);
    change = 1'b0;
    step(6);
    chk("cde_emitting", 32'(busy), 32'd1);
    key = 16'h0100;
    for (int i = 0; i < 8; i++) expect_ev(1'b0, 4'(i));
    expect_ev(1'b1, 4'd8);
    step(20);
    wait_idle("change_during_emit");
    chk("cde_stable", 32'(stable_keys), 32'h0100);

    // Reset mid-EMIT with two events queued (they are discarded, so not expected)
    ev_if.ev_ready = 1'b0;
    key = 16'h0103; change = 1'b1;
    step(1);
    change = 1'b0;
    step(6);
    chk("rme_queued", 32'(ev_if.ev_valid), 32'd1);
    chk("rme_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rme_valid", 32'(ev_if.ev_valid), 32'd0);
    chk("rme_stable", 32'(stable_keys), 32'h0000);
    chk("rme_busy_rst", 32'(busy), 32'd0);
    key = 16'h0000;
    step(2);
    rst_n = 1'b1;
    ev_if.ev_ready = 1'b1;
    step(30);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_valid", 32'(ev_if.ev_valid), 32'd0);

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
